// File: rtl/mac_operand_issuer_pkg.sv
// Shared constants and types for the MAC operand issue path.
package mac_operand_issuer_pkg;

    localparam int MAC_MIN_WIDTH  = 8;
    localparam int MAC_CONF_WIDTH = 3;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_DUAL   = 2'd1;
    localparam logic [1:0] MODE_QUAD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } issue_state_t;

endpackage

// File: rtl/mac_operand_issuer_if.sv
// Operand beat handshake plus per-lane operand/control bus between producer, issuer and combiner.
interface mac_operand_issuer_if
    import mac_operand_issuer_pkg::*;
#(
    parameter int MIN_W  = MAC_MIN_WIDTH,
    parameter int CONF_W = MAC_CONF_WIDTH
);
    logic [CONF_W-1:0]  cfg_mode;
    logic               in_valid;
    logic               in_ready;
    logic [4*MIN_W-1:0] in_a;
    logic [4*MIN_W-1:0] in_b;
    logic               in_last;
    logic [4*MIN_W-1:0] lane_a0, lane_a1, lane_a2, lane_a3;
    logic [MIN_W-1:0]   lane_b0, lane_b1, lane_b2, lane_b3;
    logic               mac_en;
    logic               acc_init;
    logic [CONF_W-1:0]  run_mode;
    logic               done;

    modport master (
        output cfg_mode, in_valid, in_a, in_b, in_last,
        input  in_ready, lane_a0, lane_a1, lane_a2, lane_a3,
        input  lane_b0, lane_b1, lane_b2, lane_b3, mac_en, acc_init, run_mode, done
    );

    modport slave (
        input  cfg_mode, in_valid, in_a, in_b, in_last,
        output in_ready, lane_a0, lane_a1, lane_a2, lane_a3,
        output lane_b0, lane_b1, lane_b2, lane_b3, mac_en, acc_init, run_mode, done
    );

endinterface

// File: rtl/mac_skid_fifo.sv
// Two-entry input buffer for operand beats; head is visible combinationally for the issue stage.
module mac_skid_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mac_operand_issuer.sv
// Issues buffered operand beats as per-lane multiplier operands and frames accumulate runs.
// state    | meaning
// ST_IDLE  | no run open; next issued beat starts a run (acc_init)
// ST_RUN   | run open, waiting for the beat carrying last
// ST_DRAIN | last beat issued; counting down until its result reaches the combiner output
module mac_operand_issuer
    import mac_operand_issuer_pkg::*;
#(
    parameter int MIN_W    = MAC_MIN_WIDTH,
    parameter int CONF_W   = MAC_CONF_WIDTH,
    parameter int PIPE_LAT = 2
) (
    input logic             clk,
    input logic             rst_n,
    mac_operand_issuer_if.slave bus
);
    localparam int DW    = 4 * MIN_W;
    localparam int FW    = 2 * DW + 1;
    localparam int MW    = CONF_W - 1;
    localparam int CNT_W = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;

    issue_state_t       state;
    logic [CNT_W-1:0]   drain_cnt;
    logic               rdy_en;
    logic [FW-1:0]      head;
    logic               fifo_empty, fifo_full;
    logic               push, issue, first_beat, drain_end;
    logic [DW-1:0]      head_a, head_b;
    logic               head_last;
    logic [MW-1:0]      mode_sel;
    logic [DW-1:0]      slice_a [4];
    logic [MIN_W-1:0]   slice_b [4];
    logic [DW-1:0]      lane_a_q [4];
    logic [MIN_W-1:0]   lane_b_q [4];
    logic               mac_en_q, acc_init_q, done_q;
    logic [CONF_W-1:0]  run_mode_q;

    assign head_a    = head[FW-1 -: DW];
    assign head_b    = head[DW:1];
    assign head_last = head[0];

    // Intake is held off during drain so the next run cannot overtake the current one's result.
    assign bus.in_ready = rdy_en && !fifo_full && (state != ST_DRAIN);
    assign push         = bus.in_valid && bus.in_ready;
    assign drain_end    = (state == ST_DRAIN) && (drain_cnt == '0);
    assign issue        = !fifo_empty && ((state != ST_DRAIN) || drain_end);
    assign first_beat   = (state != ST_RUN);
    assign mode_sel     = first_beat ? bus.cfg_mode[MW-1:0] : run_mode_q[MW-1:0];

    mac_skid_fifo #(.W(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({bus.in_a, bus.in_b, bus.in_last}),
        .pop   (issue),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Undefined mode codes fall through to the single-width slicing.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slice_a[i] = DW'(head_a[i*MIN_W +: MIN_W]);
            slice_b[i] = head_b[i*MIN_W +: MIN_W];
            if (mode_sel == MW'(MODE_DUAL))
                slice_a[i] = DW'((i < 2) ? head_a[2*MIN_W-1:0] : head_a[DW-1:2*MIN_W]);
            else if (mode_sel == MW'(MODE_QUAD))
                slice_a[i] = head_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain_cnt  <= '0;
            rdy_en     <= 1'b0;
            mac_en_q   <= 1'b0;
            acc_init_q <= 1'b0;
            done_q     <= 1'b0;
            run_mode_q <= '0;
            for (int i = 0; i < 4; i++) begin
                lane_a_q[i] <= '0;
                lane_b_q[i] <= '0;
            end
        end else begin
            rdy_en     <= 1'b1;
            mac_en_q   <= issue;
            acc_init_q <= issue && first_beat;
            done_q     <= drain_end;
            if (issue) begin
                for (int i = 0; i < 4; i++) begin
                    lane_a_q[i] <= slice_a[i];
                    lane_b_q[i] <= slice_b[i];
                end
                if (first_beat) run_mode_q <= bus.cfg_mode;
            end
            // A new run may issue on the same edge the previous one finishes draining.
            if (issue && head_last) begin
                state     <= ST_DRAIN;
                drain_cnt <= CNT_W'(PIPE_LAT - 1);
            end else if (issue) begin
                state <= ST_RUN;
            end else if (drain_end) begin
                state <= ST_IDLE;
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.lane_a0  = lane_a_q[0];
    assign bus.lane_a1  = lane_a_q[1];
    assign bus.lane_a2  = lane_a_q[2];
    assign bus.lane_a3  = lane_a_q[3];
    assign bus.lane_b0  = lane_b_q[0];
    assign bus.lane_b1  = lane_b_q[1];
    assign bus.lane_b2  = lane_b_q[2];
    assign bus.lane_b3  = lane_b_q[3];
    assign bus.mac_en   = mac_en_q;
    assign bus.acc_init = acc_init_q;
    assign bus.run_mode = run_mode_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_mac_operand_issuer.sv
// Directed bench for mac_operand_issuer: slicing, run framing, drain blocking and reset recovery.
module tb_mac_operand_issuer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    mac_operand_issuer_if #(.MIN_W(8), .CONF_W(3)) bus ();

    mac_operand_issuer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Event log sampled on the falling edge; the stimulus block reads it one time unit later.
    int          cyc_cnt = 0, en_total = 0, acc_total = 0, init_total = 0, done_total = 0, spur_cnt = 0;
    int          init_cyc = 0, last_en_cyc = 0, last_done_cyc = 0;
    logic [31:0] log_a [256];
    logic [31:0] log_r [256];

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (bus.mac_en) begin
            en_total    <= en_total + 1;
            last_en_cyc <= cyc_cnt;
            log_a[en_total[7:0]] <= bus.lane_a0;
            log_r[en_total[7:0]] <= {bus.lane_a3[7:0], bus.lane_a2[7:0], bus.lane_a1[7:0], bus.lane_a0[7:0]};
            if (en_total >= acc_total) spur_cnt <= spur_cnt + 1;
            if (bus.acc_init) begin
                init_total <= init_total + 1;
                init_cyc   <= cyc_cnt;
            end
        end
        if (bus.done) begin
            done_total    <= done_total + 1;
            last_done_cyc <= cyc_cnt;
        end
        if (bus.in_valid && bus.in_ready) acc_total <= acc_total + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !bus.in_ready; i++) step();
        check("send_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_en();
        for (int i = 0; i < 20 && !bus.mac_en; i++) step();
        check("wait_mac_en", 32'(bus.mac_en), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !bus.done; i++) step();
        check("wait_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, init0, done0, a_done;
        logic [31:0] sent [8];
        int gaps [8];
        gaps = '{0, 2, 0, 1, 0, 3, 0, 0};

        bus.cfg_mode = 3'b000;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;

        // 1: reset state and release
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mac_en", 32'(bus.mac_en), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_run_mode", 32'(bus.run_mode), 32'd0);
        check("rst_lane_a0", bus.lane_a0, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_same_cycle", 32'(bus.in_ready), 32'd0);
        step();
        check("rel_ready_next_cycle", 32'(bus.in_ready), 32'd1);

        // 2: SINGLE one-beat run
        bus.cfg_mode = 3'b100;
        send(32'h04030201, 32'h08070605, 1'b1);
        wait_en();
        check("s_lane_a0", bus.lane_a0, 32'h1);
        check("s_lane_a1", bus.lane_a1, 32'h2);
        check("s_lane_a2", bus.lane_a2, 32'h3);
        check("s_lane_a3", bus.lane_a3, 32'h4);
        check("s_lane_b0", 32'(bus.lane_b0), 32'h5);
        check("s_lane_b3", 32'(bus.lane_b3), 32'h8);
        check("s_acc_init", 32'(bus.acc_init), 32'd1);
        check("s_run_mode", 32'(bus.run_mode), 32'h4);
        step();
        check("s_en_drop", 32'(bus.mac_en), 32'd0);
        check("s_done_early", 32'(bus.done), 32'd0);
        step();
        check("s_done_pulse", 32'(bus.done), 32'd1);
        step();
        check("s_done_clear", 32'(bus.done), 32'd0);

        // 3: DUAL and QUAD slicing
        bus.cfg_mode = 3'b001;
        send(32'hBEEF1234, 32'h0, 1'b1);
        wait_en();
        check("d_lane_a0", bus.lane_a0, 32'h1234);
        check("d_lane_a1", bus.lane_a1, 32'h1234);
        check("d_lane_a2", bus.lane_a2, 32'hBEEF);
        check("d_lane_a3", bus.lane_a3, 32'hBEEF);
        wait_done();
        bus.cfg_mode = 3'b010;
        send(32'hDEADBEEF, 32'h44332211, 1'b1);
        wait_en();
        check("q_lane_a0", bus.lane_a0, 32'hDEADBEEF);
        check("q_lane_a2", bus.lane_a2, 32'hDEADBEEF);
        check("q_lane_a3", bus.lane_a3, 32'hDEADBEEF);
        check("q_lane_b0", 32'(bus.lane_b0), 32'h11);
        check("q_lane_b3", 32'(bus.lane_b3), 32'h44);
        check("q_run_mode", 32'(bus.run_mode), 32'h2);
        wait_done();

        // 4: four back-to-back QUAD beats in one run
        en0 = en_total; init0 = init_total; done0 = done_total;
        for (int k = 0; k < 4; k++)
            send(32'(k + 1) * 32'h11111111, 32'(k), k == 3);
        wait_done();
        check("b2b_en_count", 32'(en_total - en0), 32'd4);
        check("b2b_init_count", 32'(init_total - init0), 32'd1);
        check("b2b_done_count", 32'(done_total - done0), 32'd1);
        check("b2b_contiguous", 32'(last_en_cyc - init_cyc), 32'd3);
        check("b2b_done_latency", 32'(last_done_cyc - last_en_cyc), 32'd2);
        check("b2b_first_beat", log_a[en0[7:0]], 32'h11111111);
        check("b2b_last_beat", log_a[8'(en0 + 3)], 32'h44444444);

        // 5: run B presented during run A's drain with a new mode
        bus.cfg_mode = 3'b001;
        done0 = done_total;
        send(32'h01020304, 32'h0, 1'b0);
        send(32'h05060708, 32'h0, 1'b1);
        for (int i = 0; i < 20 && bus.in_ready; i++) step();
        check("drain_blocks_ready", 32'(bus.in_ready), 32'd0);
        bus.cfg_mode = 3'b010;
        step();
        check("drain_mode_held", 32'(bus.run_mode), 32'h1);
        send(32'hCAFEF00D, 32'h0, 1'b1);
        a_done = last_done_cyc;
        check("a_done_before_b", 32'(done_total - done0), 32'd1);
        wait_en();
        check("b_acc_init", 32'(bus.acc_init), 32'd1);
        check("b_run_mode", 32'(bus.run_mode), 32'h2);
        check("b_lane_a3", bus.lane_a3, 32'hCAFEF00D);
        check("b_after_a_done", 32'(init_cyc > a_done), 32'd1);
        wait_done();

        // 6: two SINGLE runs with valid gaps; every beat issued once and in order
        bus.cfg_mode = 3'b000;
        en0 = en_total; init0 = init_total; done0 = done_total;
        for (int i = 0; i < 8; i++) begin
            sent[i] = 32'hA0B0C0D0 + 32'(i) * 32'h01010101;
            for (int g = 0; g < gaps[i]; g++) step();
            send(sent[i], 32'(i), (i == 3) || (i == 7));
        end
        for (int i = 0; i < 10; i++) step();
        check("gap_en_count", 32'(en_total - en0), 32'd8);
        check("gap_init_count", 32'(init_total - init0), 32'd2);
        check("gap_done_count", 32'(done_total - done0), 32'd2);
        check("gap_no_spurious_en", 32'(spur_cnt), 32'd0);
        for (int i = 0; i < 8; i++)
            check($sformatf("gap_order_%0d", i), log_r[8'(en0 + i)], sent[i]);

        // 7: reset in the middle of a run
        bus.cfg_mode = 3'b010;
        bus.in_a     = 32'h77777777;
        bus.in_b     = 32'h0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        step();
        step();
        check("mid_run_en", 32'(bus.mac_en), 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        done0 = done_total;
        #1;
        check("mid_rst_mac_en", 32'(bus.mac_en), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_lane_a0", bus.lane_a0, 32'd0);
        check("mid_rst_run_mode", 32'(bus.run_mode), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_no_done", 32'(done_total - done0), 32'd0);
        bus.cfg_mode = 3'b000;
        en0 = en_total;
        send(32'h0A0B0C0D, 32'h0, 1'b1);
        wait_en();
        check("post_rst_acc_init", 32'(bus.acc_init), 32'd1);
        check("post_rst_lane_a0", bus.lane_a0, 32'h0D);
        wait_done();
        check("post_rst_one_beat", 32'(en_total - en0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
